bcd_mmss_timer: RTL and testbench
=================================

# bcd_mmss_timer

Minutes:seconds BCD stopwatch/countdown timer driven by the half-second tick pulse of the `one_second` prescaler. It sits directly downstream of that prescaler in the add16 board design. It counts qualified ticks into a BCD mm:ss value for the seven-segment display path. Start/stop, clear, countdown preset and expiry flag make it the user-facing timing stage.

## Interface
Parameters:
- `TICKS_PER_SEC`, 2, tick pulses per second. The upstream prescaler pulses every 0.5 s. Legal range 1..255.
- `MIN_MAX`, 59, highest minutes value. Decimal, legal 1..99.

Ports:
- `CLK1`  in  1  system clock, 50 MHz
- `arst`  in  1  reset; synchronous, active-high, sampled on rising `CLK1`
- `tick`  in  1  single-cycle pulse from `one_second`
- `start`  in  1  level; each rising edge toggles run/pause
- `clear`  in  1  level; returns to IDLE
- `down`  in  1  1 = countdown mode; sampled only in IDLE
- `preset_min`  in  8  BCD countdown preset, minutes
- `preset_sec`  in  8  BCD countdown preset, seconds
- `min_bcd`  out  8  BCD minutes, tens digit in [7:4]
- `sec_bcd`  out  8  BCD seconds, tens digit in [7:4]
- `running`  out  1  high in RUN
- `expired`  out  1  high in EXPIRED
- `sec_pulse`  out  1  one-cycle pulse on every displayed-value step

## Operation
- Reset values: state IDLE, prescaler 0, `min_bcd`=`sec_bcd`=8'h00, `running`=`expired`=`sec_pulse`=0, latched mode = up, start edge register = 1.
  - Because the start edge register resets to 1, a `start` held high through reset gives no edge.
- Start edge: `start & ~start_q`.
- Priority: `arst` > `clear` > start edge > `tick`.
- IDLE:
  - Mode latches from `down` every cycle.
  - Count loads 00:00 in up mode, or the sanitized preset in down mode, every cycle.
  - Preset sanitizing: any digit >9 becomes 9; seconds tens >5 becomes 5; minutes above `MIN_MAX` become `MIN_MAX`.
  - Start edge → RUN.
  - If down mode and the preset is 00:00, a start edge → EXPIRED instead.
- RUN:
  - A tick increments the prescaler.
  - A tick with prescaler = `TICKS_PER_SEC`-1 clears the prescaler and steps the count by one second.
  - Up mode: sec 59 → 00 with minutes +1; `MIN_MAX`:59 → 00:00 (wrap, no flag).
  - Down mode: sec 00 → 59 with minutes −1; a step that reaches 00:00 → EXPIRED.
  - Start edge → PAUSE. A tick in the same cycle is discarded.
- PAUSE: count and prescaler hold; ticks ignored; start edge → RUN.
- EXPIRED: count holds 00:00; start edge and ticks ignored.
- `clear` in any state → IDLE with prescaler 0.
- Ticks in IDLE are ignored.

## Timing
- All outputs are registered.
- Count change and `sec_pulse` are visible the cycle after the qualifying tick.
- `running`/`expired` change the cycle after the start edge or final decrement is sampled.
- `clear` takes effect on the next edge. The IDLE reload value is visible one cycle later.
- `arst` mid-count: the next edge forces the reset values, regardless of state.
- `tick` is assumed to be at most one cycle wide. A multi-cycle-high tick counts once per cycle.

## Configuration
- `BCD_TIMER_LAP_EN` defined:
  - Adds input `lap` (1 bit, rising-edge detected, reset edge register = 1).
  - A lap edge in RUN freezes `min_bcd`/`sec_bcd` at the current value while internal counting continues. `sec_pulse` is suppressed while frozen.
  - The next lap edge releases the freeze. `clear`, `arst` or entering EXPIRED also release it.
- Not defined: no `lap` port; outputs always mirror the internal count.

## Structure
- Package `bcd_timer_pkg`:
  - state enum (IDLE, RUN, PAUSE, EXPIRED)
  - `bcd_digit_t` (4-bit)
  - constants `SEC_TENS_MAX`=5 and `DIGIT_MAX`=9
- Sub-module `bcd_digit_counter`:
  - one digit with enable, direction, configurable max, wrap, and carry/borrow out
  - instantiated four times in a ripple chain

## Test plan
- Up count: reset, start edge, 120 ticks → 01:00 with 60 `sec_pulse`s. From 59:59 one second more → 00:00.
- Down count: `down`=1, preset 00:03, start, 6 ticks → 00:00 and `expired`=1. Further ticks and start edges → no change.
- Pause: start, 3 ticks, start edge coincident with 4th tick → PAUSE at 00:01 with prescaler 1. 10 ticks → no change. Start, 1 tick → 00:02.
- Preset sanitizing: preset_min 8'h7A, preset_sec 8'h9F, `down`=1, start at `MIN_MAX`=59 → 59:59 loaded. Zero preset → EXPIRED on first start edge.
- Clear/reset mid-run: `clear` at 12:34 → 00:00 IDLE next cycle. `arst` in EXPIRED → all outputs 0.
- Lap (with `BCD_TIMER_LAP_EN`): lap at 00:05, 10 ticks → outputs hold 00:05. Second lap → 00:10 shown.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD mm:ss timer.
// Optional lap/freeze feature of the top is enabled by BCD_TIMER_LAP_EN.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t DIGIT_MAX    = 4'd9;

  function automatic bcd_digit_t sat_digit(input bcd_digit_t d, input bcd_digit_t mx);
    return (d > mx) ? mx : d;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit step: next value and carry/borrow for a ripple chain.
module bcd_digit_counter
  import bcd_timer_pkg::*;
(
  input  bcd_digit_t d,
  input  logic       en,
  input  logic       dn,
  input  bcd_digit_t dmax,
  output bcd_digit_t q,
  output logic       co
);

  logic at_lim;

  assign at_lim = dn ? (d == 4'd0) : (d == dmax);
  assign co     = en & at_lim;

  // At the limit the digit wraps: up to 0, down to dmax.
  always_comb begin
    q = d;
    if (en) begin
      if (dn) q = at_lim ? dmax : d - 4'd1;
      else    q = at_lim ? 4'd0 : d + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_mmss_timer.sv
// BCD mm:ss stopwatch/countdown timer fed by the prescaler tick.
// Define BCD_TIMER_LAP_EN to add the lap input and display freeze.
module bcd_mmss_timer
  import bcd_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 2,
  parameter int MIN_MAX       = 59
) (
  input  logic       CLK1,
  input  logic       arst,
  input  logic       tick,
  input  logic       start,
  input  logic       clear,
  input  logic       down,
`ifdef BCD_TIMER_LAP_EN
  input  logic       lap,
`endif
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       sec_pulse
);

  localparam logic [7:0] PS_TOP  = 8'(TICKS_PER_SEC - 1);
  localparam bcd_digit_t MT_TENS = 4'(MIN_MAX / 10);
  localparam bcd_digit_t MT_ONES = 4'(MIN_MAX % 10);

  state_t           state, state_n;
  logic [7:0]       presc, presc_n;
  logic             mode_dn, mode_n;
  logic             start_q, start_edge;
  logic             step, frozen_n;
  bcd_digit_t [3:0] cnt, cnt_n, cnt_step, dmax, reload;
  logic       [4:0] cy;

  assign start_edge = start & ~start_q;

  // Preset sanitizing
  bcd_digit_t pm_t, pm_o, ps_t, ps_o;
  logic [6:0] pm_val;

  assign ps_o   = sat_digit(preset_sec[3:0], DIGIT_MAX);
  assign ps_t   = sat_digit(preset_sec[7:4], SEC_TENS_MAX);
  assign pm_o   = sat_digit(preset_min[3:0], DIGIT_MAX);
  assign pm_t   = sat_digit(preset_min[7:4], DIGIT_MAX);
  assign pm_val = 7'(pm_t) * 7'd10 + 7'(pm_o);

  always_comb begin
    reload = '0;
    if (down) begin
      if (pm_val > 7'(MIN_MAX)) reload = {MT_TENS, MT_ONES, ps_t, ps_o};
      else                      reload = {pm_t, pm_o, ps_t, ps_o};
    end
  end

  // Minutes-ones only caps below 9 on the top decade while counting up.
  assign dmax[0] = DIGIT_MAX;
  assign dmax[1] = SEC_TENS_MAX;
  assign dmax[2] = (mode_dn || cnt[3] != MT_TENS) ? DIGIT_MAX : MT_ONES;
  assign dmax[3] = MT_TENS;

  assign cy[0] = 1'b1;
  for (genvar i = 0; i < 4; i++) begin : g_dig
    bcd_digit_counter u_dig (
      .d    (cnt[i]),
      .en   (cy[i]),
      .dn   (mode_dn),
      .dmax (dmax[i]),
      .q    (cnt_step[i]),
      .co   (cy[i+1])
    );
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    presc_n = presc;
    mode_n  = mode_dn;
    step    = 1'b0;
    if (clear) begin
      state_n = IDLE;
      cnt_n   = '0;
      presc_n = '0;
    end else begin
      case (state)
        IDLE: begin
          mode_n  = down;
          cnt_n   = reload;
          presc_n = '0;
          if (start_edge) state_n = (down && reload == '0) ? EXPIRED : RUN;
        end
        RUN: begin
          if (start_edge) state_n = PAUSE;
          else if (tick) begin
            if (presc == PS_TOP) begin
              presc_n = '0;
              cnt_n   = cnt_step;
              step    = 1'b1;
              // A borrow out of the top digit is treated as expiry too.
              if (mode_dn && (cnt_step == '0 || cy[4])) begin
                state_n = EXPIRED;
                cnt_n   = '0;
              end
            end else begin
              presc_n = presc + 8'd1;
            end
          end
        end
        PAUSE: if (start_edge) state_n = RUN;
        EXPIRED: cnt_n = '0;
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef BCD_TIMER_LAP_EN
  logic lap_q, frozen;
  logic lap_edge;

  assign lap_edge = lap & ~lap_q;

  always_comb begin
    frozen_n = frozen;
    if (clear || state_n == EXPIRED) frozen_n = 1'b0;
    else if (lap_edge)               frozen_n = frozen ? 1'b0 : (state == RUN);
  end

  always_ff @(posedge CLK1) begin
    if (arst) begin
      lap_q  <= 1'b1;
      frozen <= 1'b0;
    end else begin
      lap_q  <= lap;
      frozen <= frozen_n;
    end
  end
`else
  assign frozen_n = 1'b0;
`endif

  always_ff @(posedge CLK1) begin
    if (arst) begin
      state     <= IDLE;
      cnt       <= '0;
      presc     <= '0;
      mode_dn   <= 1'b0;
      start_q   <= 1'b1;
      min_bcd   <= '0;
      sec_bcd   <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
      sec_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      presc     <= presc_n;
      mode_dn   <= mode_n;
      start_q   <= start;
      running   <= (state_n == RUN);
      expired   <= (state_n == EXPIRED);
      sec_pulse <= step & ~frozen_n;
      if (!frozen_n) begin
        min_bcd <= {cnt_n[3], cnt_n[2]};
        sec_bcd <= {cnt_n[1], cnt_n[0]};
      end
    end
  end

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// Directed bench for bcd_mmss_timer: vector table plus long-count sequences.
module tb_bcd_mmss_timer;

  logic       CLK1 = 1'b0;
  logic       arst, tick, start, clear, down;
  logic [7:0] preset_min, preset_sec;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, expired, sec_pulse;
`ifdef BCD_TIMER_LAP_EN
  logic       lap;
`endif

  int ntests = 0;
  int nfail  = 0;
  int npulse;

  always #5 CLK1 = ~CLK1;

  bcd_mmss_timer #(.TICKS_PER_SEC(2), .MIN_MAX(59)) dut (
    .CLK1       (CLK1),
    .arst       (arst),
    .tick       (tick),
    .start      (start),
    .clear      (clear),
    .down       (down),
`ifdef BCD_TIMER_LAP_EN
    .lap        (lap),
`endif
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .running    (running),
    .expired    (expired),
    .sec_pulse  (sec_pulse)
  );

  typedef struct packed {
    logic       rst, clr, st, tk, dn;
    logic [7:0] pm, ps;
    logic [7:0] em, es;
    logic       er, ee, ep;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rst, clr, st, tk, dn,
                              input logic [7:0] pm, ps, em, es,
                              input logic er, ee, ep);
    vec_t v;
    v = '{rst, clr, st, tk, dn, pm, ps, em, es, er, ee, ep};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK1);
    #1;
    if (sec_pulse) npulse++;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    tick = 1'b0;
  endtask

  initial begin
    arst = 1'b1; tick = 1'b0; start = 1'b0; clear = 1'b0; down = 1'b0;
    preset_min = 8'h00; preset_sec = 8'h00;
`ifdef BCD_TIMER_LAP_EN
    lap = 1'b0;
`endif
    npulse = 0;

    //          rst clr st tk dn  pm     ps     em     es    run exp pls
    vt.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0)); // 0 reset
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0)); // 1 idle
    vt.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0)); // 2 start
    vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0)); // 3 presc 1
    vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 1)); // 4 step
    vt.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0)); // 5
    vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0)); // 6 presc 1
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0)); // 7
    vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 0)); // 8 pause, tick lost
    vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 0)); // 9 paused
    vt.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 0)); // 10 paused
    vt.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0)); // 11 resume
    vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 1)); // 12 presc kept
    vt.push_back(mk(0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0)); // 13 clear
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h03, 8'h00, 8'h03, 0, 0, 0)); // 14 preset load
    vt.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h03, 8'h00, 8'h03, 1, 0, 0)); // 15 start down
    vt.push_back(mk(0, 0, 1, 1, 1, 8'h00, 8'h03, 8'h00, 8'h03, 1, 0, 0)); // 16
    vt.push_back(mk(0, 0, 1, 1, 1, 8'h00, 8'h03, 8'h00, 8'h02, 1, 0, 1)); // 17
    vt.push_back(mk(0, 0, 1, 1, 1, 8'h00, 8'h03, 8'h00, 8'h02, 1, 0, 0)); // 18
    vt.push_back(mk(0, 0, 1, 1, 1, 8'h00, 8'h03, 8'h00, 8'h01, 1, 0, 1)); // 19
    vt.push_back(mk(0, 0, 1, 1, 1, 8'h00, 8'h03, 8'h00, 8'h01, 1, 0, 0)); // 20
    vt.push_back(mk(0, 0, 1, 1, 1, 8'h00, 8'h03, 8'h00, 8'h00, 0, 1, 1)); // 21 expire
    vt.push_back(mk(0, 0, 1, 1, 1, 8'h00, 8'h03, 8'h00, 8'h00, 0, 1, 0)); // 22 tick ignored
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h03, 8'h00, 8'h00, 0, 1, 0)); // 23
    vt.push_back(mk(0, 0, 1, 1, 1, 8'h00, 8'h03, 8'h00, 8'h00, 0, 1, 0)); // 24 start ignored
    vt.push_back(mk(1, 0, 0, 0, 1, 8'h00, 8'h03, 8'h00, 8'h00, 0, 0, 0)); // 25 arst in EXPIRED
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h7A, 8'h9F, 8'h59, 8'h59, 0, 0, 0)); // 26 sanitize
    vt.push_back(mk(0, 0, 1, 0, 1, 8'h7A, 8'h9F, 8'h59, 8'h59, 1, 0, 0)); // 27
    vt.push_back(mk(0, 0, 1, 1, 1, 8'h7A, 8'h9F, 8'h59, 8'h59, 1, 0, 0)); // 28
    vt.push_back(mk(0, 0, 1, 1, 1, 8'h7A, 8'h9F, 8'h59, 8'h58, 1, 0, 1)); // 29
    vt.push_back(mk(0, 1, 0, 0, 1, 8'h7A, 8'h9F, 8'h00, 8'h00, 0, 0, 0)); // 30 clear
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0)); // 31 zero preset
    vt.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0)); // 32 instant expire
    vt.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0)); // 33 clear

    for (int i = 0; i < vt.size(); i++) begin
      arst = vt[i].rst; clear = vt[i].clr; start = vt[i].st; tick = vt[i].tk;
      down = vt[i].dn; preset_min = vt[i].pm; preset_sec = vt[i].ps;
      cyc();
      chk($sformatf("vec%0d", i),
          {13'd0, min_bcd, sec_bcd, running, expired, sec_pulse},
          {13'd0, vt[i].em, vt[i].es, vt[i].er, vt[i].ee, vt[i].ep});
    end

    // Up count: two minutes of ticks, then full wrap, then clear mid-run.
    arst = 1'b0; clear = 1'b0; down = 1'b0; preset_min = 8'h00; preset_sec = 8'h00;
    start = 1'b1; tick = 1'b0;
    cyc();
    chk("up_running", {31'd0, running}, 32'd1);
    npulse = 0;
    ticks(120);
    chk("up_0100", {16'd0, min_bcd, sec_bcd}, 32'h0100);
    chk("up_pulses", npulse, 32'd60);
    ticks(7078);
    chk("up_5959", {16'd0, min_bcd, sec_bcd}, 32'h5959);
    ticks(2);
    chk("up_wrap", {14'd0, min_bcd, sec_bcd, running, expired}, {14'd0, 16'h0000, 2'b10});
    ticks(1508);
    chk("up_1234", {16'd0, min_bcd, sec_bcd}, 32'h1234);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clear_1234", {15'd0, min_bcd, sec_bcd, running}, {15'd0, 16'h0000, 1'b0});

`ifdef BCD_TIMER_LAP_EN
    // Lap: freeze display at 00:05 while counting on to 00:10.
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    ticks(10);
    chk("lap_pre", {16'd0, min_bcd, sec_bcd}, 32'h0005);
    lap = 1'b1;
    cyc();
    lap = 1'b0;
    npulse = 0;
    ticks(10);
    chk("lap_hold", {16'd0, min_bcd, sec_bcd}, 32'h0005);
    chk("lap_nopulse", npulse, 32'd0);
    lap = 1'b1;
    cyc();
    lap = 1'b0;
    chk("lap_release", {16'd0, min_bcd, sec_bcd}, 32'h0010);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
